// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: walks a 16:1 mux select over a masked channel range, dwelling on
// each enabled channel before sampling its output into a result word.
module mux_scan_ctrl #(
    parameter int N_CH  = 16,
    parameter int SEL_W = 4,
    parameter int DWELL = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [SEL_W-1:0] first_ch,
    input  logic [SEL_W-1:0] last_ch,
    input  logic [N_CH-1:0]  ch_mask,
    input  logic             mux_out,
    output logic [SEL_W-1:0] sel,
    output logic             busy,
    output logic             done,
    output logic [N_CH-1:0]  result
);
    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
    localparam logic [3:0] DW_LAST = 4'(DWELL - 1);
    state_t           state;
    logic [3:0]       cnt;
    logic [SEL_W-1:0] last_q;
    logic [N_CH-1:0]  mask_q;
    // first_ch is consumed directly into sel at start, so only the end of range is kept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sel    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            cnt    <= '0;
            last_q <= '0;
            mask_q <= '0;
        end else begin
            case (state)
                IDLE: if (start && !abort) begin
                    last_q <= last_ch;
                    mask_q <= ch_mask;
                    result <= '0;
                    sel    <= first_ch;
                    busy   <= 1'b1;
                    cnt    <= '0;
                    state  <= SCAN;
                end
                SCAN: if (abort) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end else if (mask_q[sel] && cnt != DW_LAST) begin
                    cnt <= cnt + 4'd1;
                end else begin
                    if (mask_q[sel]) result[sel] <= mux_out;
                    cnt <= '0;
                    if (sel == last_q) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        sel <= sel + 1'b1;
                    end
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: drives DWELL=2 and DWELL=3 instances in lockstep and checks them
// every cycle against a schedule-based model, plus literal scan results and lengths.
module tb_mux_scan_ctrl;
    logic        clk, rst_n, start, abort;
    logic [3:0]  first_ch, last_ch;
    logic [15:0] ch_mask, data;
    logic [3:0]  sel0, sel1;
    logic        busy0, busy1, done0, done1;
    logic [15:0] res0, res1;
    logic        mux0, mux1;
    int          n_checks = 0, n_fail = 0;

    assign mux0 = data[sel0];
    assign mux1 = data[sel1];

    mux_scan_ctrl #(.DWELL(2)) dut0 (.clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .first_ch(first_ch), .last_ch(last_ch), .ch_mask(ch_mask), .mux_out(mux0),
        .sel(sel0), .busy(busy0), .done(done0), .result(res0));
    mux_scan_ctrl #(.DWELL(3)) dut1 (.clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .first_ch(first_ch), .last_ch(last_ch), .ch_mask(ch_mask), .mux_out(mux1),
        .sel(sel1), .busy(busy1), .done(done1), .result(res1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scan schedule: walk channels from f, each taking dw cycles if enabled else 1
    function automatic int scan_len(int f, int l, logic [15:0] m, int dw);
        int c = f, n = 0;
        for (int k = 0; k < 16; k++) begin
            n += m[c] ? dw : 1;
            if (c == l) break;
            c = (c + 1) % 16;
        end
        return n;
    endfunction

    function automatic int chan_at(int f, logic [15:0] m, int dw, int t);
        int c = f, acc = 0;
        for (int k = 0; k < 16; k++) begin
            if (t < acc + (m[c] ? dw : 1)) return c;
            acc += m[c] ? dw : 1;
            c = (c + 1) % 16;
        end
        return c;
    endfunction

    function automatic bit sample_at(int f, logic [15:0] m, int dw, int t);
        int c = f, acc = 0;
        for (int k = 0; k < 16; k++) begin
            if (t < acc + (m[c] ? dw : 1)) return m[c] && (t == acc + dw - 1);
            acc += m[c] ? dw : 1;
            c = (c + 1) % 16;
        end
        return 1'b0;
    endfunction

    logic        m_act[2], m_done[2];
    int          m_t[2];
    logic [3:0]  m_sel[2], m_f[2], m_l[2];
    logic [15:0] m_m[2], m_res[2];

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_act[d] <= 1'b0; m_done[d] <= 1'b0; m_t[d] <= 0; m_sel[d] <= '0;
                m_f[d] <= '0; m_l[d] <= '0; m_m[d] <= '0; m_res[d] <= '0;
            end else if (m_done[d]) begin
                m_done[d] <= 1'b0;
            end else if (!m_act[d]) begin
                if (start && !abort) begin
                    m_act[d] <= 1'b1; m_t[d] <= 0; m_f[d] <= first_ch; m_l[d] <= last_ch;
                    m_m[d] <= ch_mask; m_res[d] <= '0; m_sel[d] <= first_ch;
                end
            end else if (abort) begin
                m_act[d] <= 1'b0;
            end else begin
                if (sample_at(int'(m_f[d]), m_m[d], 2 + d, m_t[d]))
                    m_res[d][chan_at(int'(m_f[d]), m_m[d], 2 + d, m_t[d])] <=
                        data[chan_at(int'(m_f[d]), m_m[d], 2 + d, m_t[d])];
                if (m_t[d] == scan_len(int'(m_f[d]), int'(m_l[d]), m_m[d], 2 + d) - 1) begin
                    m_act[d]  <= 1'b0;
                    m_done[d] <= 1'b1;
                end else begin
                    m_t[d]   <= m_t[d] + 1;
                    m_sel[d] <= 4'(chan_at(int'(m_f[d]), m_m[d], 2 + d, m_t[d] + 1));
                end
            end
        end
    end

    always @(negedge clk) begin
        check("sel0", 32'(sel0), 32'(m_sel[0]));
        check("busy0", 32'(busy0), 32'(m_act[0]));
        check("done0", 32'(done0), 32'(m_done[0]));
        check("result0", 32'(res0), 32'(m_res[0]));
        check("sel1", 32'(sel1), 32'(m_sel[1]));
        check("busy1", 32'(busy1), 32'(m_act[1]));
        check("done1", 32'(done1), 32'(m_done[1]));
        check("result1", 32'(res1), 32'(m_res[1]));
    end

    task automatic start_scan(input logic [3:0] f, input logic [3:0] l, input logic [15:0] m,
                              input logic [15:0] dat);
        @(negedge clk);
        first_ch = f; last_ch = l; ch_mask = m; data = dat; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts busy/done cycles until both instances are idle; rp/ab pulse start/abort at that cycle
    task automatic measure(input int rp, input int ab, output int b0, output int b1,
                           output int d0, output int d1);
        int i;
        b0 = 0; b1 = 0; d0 = 0; d1 = 0;
        for (i = 0; i < 300; i++) begin
            b0 += int'(busy0); b1 += int'(busy1); d0 += int'(done0); d1 += int'(done1);
            if (!busy0 && !busy1 && !done0 && !done1) break;
            start = (i == rp);
            abort = (i == ab);
            @(negedge clk);
        end
        start = 1'b0; abort = 1'b0;
        if (i == 300) check("scan_timeout", 32'(i), 32'd0);
    endtask

    int b0, b1, d0, d1;

    initial begin
        rst_n = 1'b1; start = 1'b0; abort = 1'b0;
        first_ch = '0; last_ch = '0; ch_mask = '0; data = '0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_sel", 32'(sel0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        check("rst_result", 32'(res0), 32'd0);
        rst_n = 1'b1;

        start_scan(4'd0, 4'd15, 16'hFFFF, 16'hA5C3);
        measure(-1, -1, b0, b1, d0, d1);
        check("full_len0", 32'(b0), 32'd32);
        check("full_len1", 32'(b1), 32'd48);
        check("full_done0", 32'(d0), 32'd1);
        check("full_done1", 32'(d1), 32'd1);
        check("full_res0", 32'(res0), 32'hA5C3);
        check("full_res1", 32'(res1), 32'hA5C3);

        start_scan(4'd0, 4'd15, 16'h00FF, 16'hA5C3);
        measure(-1, -1, b0, b1, d0, d1);
        check("mask_len0", 32'(b0), 32'd24);
        check("mask_len1", 32'(b1), 32'd32);
        check("mask_res0", 32'(res0), 32'h00C3);

        start_scan(4'd14, 4'd1, 16'hFFFF, 16'hA5C3);
        measure(-1, -1, b0, b1, d0, d1);
        check("wrap_len0", 32'(b0), 32'd8);
        check("wrap_res0", 32'(res0), 32'h8003);

        start_scan(4'd0, 4'd15, 16'hFFFF, 16'hA5C3);
        measure(-1, 6, b0, b1, d0, d1);
        check("abort_len0", 32'(b0), 32'd7);
        check("abort_done0", 32'(d0), 32'd0);
        check("abort_done1", 32'(d1), 32'd0);
        check("abort_res0", 32'(res0), 32'h0003);
        check("abort_res1", 32'(res1), 32'h0003);

        start_scan(4'd0, 4'd15, 16'hFFFF, 16'hA5C3);
        measure(4, -1, b0, b1, d0, d1);
        check("coll_len0", 32'(b0), 32'd32);
        check("coll_done0", 32'(d0), 32'd1);
        check("coll_res0", 32'(res0), 32'hA5C3);

        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("startabort_busy0", 32'(busy0), 32'd0);
        check("startabort_busy1", 32'(busy1), 32'd0);

        start_scan(4'd0, 4'd15, 16'hFFFF, 16'hA5C3);
        repeat (5) @(negedge clk);
        check("prerst_res0", 32'(res0), 32'h0003);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_sel0", 32'(sel0), 32'd0);
        check("midrst_busy0", 32'(busy0), 32'd0);
        check("midrst_done0", 32'(done0), 32'd0);
        check("midrst_res0", 32'(res0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        start_scan(4'd5, 4'd5, 16'hFFFF, 16'h0020);
        measure(-1, -1, b0, b1, d0, d1);
        check("single_len0", 32'(b0), 32'd2);
        check("single_len1", 32'(b1), 32'd3);
        check("single_res0", 32'(res0), 32'h0020);
        check("single_res1", 32'(res1), 32'h0020);
        check("single_sel1", 32'(sel1), 32'd5);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
Sequencer for the 16:1 single-bit multiplexer. On a start request it walks the mux select across a programmable channel range, skipping masked channels. For each enabled channel it holds the select for a settle/dwell period, then samples the mux output and assembles the samples into a 16-bit result word. It reports completion with a busy/done handshake to the issuing controller.

Parameters:
N_CH, 16, number of mux channels (fixed at 16 for this revision)
SEL_W, 4, select width, log2(N_CH)
DWELL, 2, cycles the select is held per enabled channel before sampling (legal range 1..15)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  scan request, sampled only in IDLE
abort  input  1  synchronous scan cancel
first_ch  input  SEL_W  first channel of scan range, latched at start
last_ch  input  SEL_W  last channel of scan range, latched at start
ch_mask  input  N_CH  1 = channel enabled, 0 = skipped; latched at start
mux_out  input  1  output of the 16:1 mux
sel  output  SEL_W  select driven to the mux
busy  output  1  high while a scan is in progress
done  output  1  one-cycle pulse when a scan completes
result  output  N_CH  result[i] = sampled mux_out for channel i

Behaviour:
- Reset (rst_n low, async): state=IDLE, sel=0, busy=0, done=0, result=0, dwell counter=0, latched config=0. Reset mid-scan discards all progress. No done is produced.
- FSM states: IDLE, SCAN, DONE.
- IDLE: sel holds its last value. When start=1 and abort=0 at an edge, the block:
  - latches first_ch, last_ch and ch_mask;
  - clears result to 0;
  - sets sel=first_ch, busy=1, dwell counter=0;
  - moves to SCAN.
- start with abort in the same cycle: abort wins, stays IDLE.
- start while busy or in DONE: ignored, no queuing.
- SCAN, enabled channel (mask[sel]=1):
  - sel is held DWELL cycles.
  - On the edge ending the DWELL-th cycle, result[sel] <= mux_out.
  - The block then advances to the next channel or finishes.
- SCAN, masked channel (mask[sel]=0): exactly 1 cycle, no sample, result bit stays 0.
- Advance: if sel==last_ch, go to DONE. Otherwise sel <= sel+1 modulo 16.
- Wrap-around: if first_ch > last_ch, the scan covers first_ch..15 then 0..last_ch. If first_ch==last_ch, exactly one channel is scanned.
- Channels outside the range read 0 in result.
- Scan length in cycles = k*DWELL + m, where k = enabled and m = masked channels in range. An all-masked range completes in m cycles with result=0.
- DONE: lasts exactly 1 cycle with done=1 and busy=0, then returns to IDLE. result holds until the next accepted start or reset.
- abort=1 in SCAN: next edge goes to IDLE with busy=0, no done pulse. result keeps the bits sampled so far. abort in DONE is ignored (done still pulses).
- mux_out is sampled only on sample edges. Changes at other times have no effect.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Full scan: DWELL=2, mux in=16'hA5C3, first=0, last=15, mask=16'hFFFF, start pulse at edge E0.
  - sel steps 0..15, changing every 2 cycles.
  - busy high for 32 cycles; done high between E32 and E33.
  - result=16'hA5C3.
- Masked scan: same data, mask=16'h00FF.
  - Channels 8..15 take 1 cycle each; busy high for 8*2+8=24 cycles.
  - result=16'h00C3.
- Wrap-around: first=14, last=1, mask=16'hFFFF, in=16'hA5C3.
  - sel sequence 14,15,0,1.
  - result=16'h8003, i.e. bits 15,14,1,0 = 1,0,1,1.
- Abort: full scan started, abort asserted at the 7th busy cycle (sel=3).
  - Next edge: IDLE, busy=0, done never asserted.
  - result holds bits 0..2 = 3'b011; the bit-3 sample is not taken.
- Start collision and reset: start re-pulsed while busy is ignored (single done, scan length unchanged). start+abort together in IDLE leaves busy=0. rst_n pulsed low mid-scan immediately drives sel=0, busy=0, done=0, result=0.
- Single channel: first=last=5, DWELL=3, in bit5=1.
  - busy for 3 cycles, then done.
  - result=16'h0020.
